// File: rtl/axis_pkt_store_fwd_if.sv
// AXI-Stream bundle for the packet store-and-forward buffer.
// The master side drives the beat; tready flows back from the slave side.
interface axis_pkt_store_fwd_if #(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_KEEP_WIDTH = 8,
    parameter int P_DEST_WIDTH = 3
);
    logic                    tvalid;
    logic                    tready;
    logic [P_DATA_WIDTH-1:0] tdata;
    logic                    tlast;
    logic [P_KEEP_WIDTH-1:0] tkeep;
    logic                    tuser;
    logic [P_DEST_WIDTH-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tkeep, tuser, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tkeep, tuser, tdest, output tready);
endinterface

// File: rtl/axis_pkt_store_fwd.sv
// Store-and-forward packet buffer in front of the DDR write master.
// Packets are held until complete and error-free, then released as one
// gapless burst when the downstream master says it can take a whole packet.
//
// Read FSM states:
//   state  | meaning
//   IDLE   | waiting for a committed packet and i_dst_ready
//   LOAD   | descriptor popped, first RAM read in flight
//   SEND   | one beat per cycle until the descriptor's beat count is done
module axis_pkt_store_fwd #(
    parameter int P_DATA_WIDTH    = 64,
    parameter int P_KEEP_WIDTH    = P_DATA_WIDTH / 8,
    parameter int P_DEST_WIDTH    = 3,
    parameter int P_FIFO_DEPTH    = 512,
    parameter int P_DESC_DEPTH    = 16,
    parameter int P_MAX_PKT_BEATS = 256
) (
    input  logic                        M_AXI_ACLK,
    input  logic                        M_AXI_ARESET,
    axis_pkt_store_fwd_if.slave         s_axis,
    axis_pkt_store_fwd_if.master        m_axis,
    input  logic                        i_dst_ready,
    output logic [15:0]                 o_pkt_cnt,
    output logic [15:0]                 o_drop_cnt
);

    localparam int AW     = $clog2(P_FIFO_DEPTH);
    localparam int PW     = AW + 1;
    localparam int DAW    = $clog2(P_DESC_DEPTH);
    localparam int DPW    = DAW + 1;
    localparam int CW     = $clog2(P_MAX_PKT_BEATS + 2);
    localparam int RAM_W  = P_KEEP_WIDTH + P_DATA_WIDTH;
    localparam int DESC_W = P_DEST_WIDTH + CW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND
    } rd_state_t;

    logic [RAM_W-1:0]        ram [P_FIFO_DEPTH];
    logic [DESC_W-1:0]       desc_mem [P_DESC_DEPTH];

    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           commit_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           used;
    logic [CW-1:0]           beat_cnt;
    logic [CW-1:0]           cnt_next;
    logic [P_DEST_WIDTH-1:0] dest_q;
    logic [P_DEST_WIDTH-1:0] pkt_dest;
    logic                    discard;
    logic                    s_ready;
    logic                    s_fire;
    logic                    commit_ok;
    logic                    push;
    logic                    pop;

    logic [DPW-1:0]          desc_wr;
    logic [DPW-1:0]          desc_rd;
    logic [DPW-1:0]          desc_used;
    logic                    desc_full;
    logic                    desc_empty;
    logic [CW-1:0]           desc_len;
    logic [P_DEST_WIDTH-1:0] desc_dest;

    rd_state_t               state;
    logic [CW-1:0]           rem;
    logic                    m_valid;
    logic                    m_last;
    logic [P_DATA_WIDTH-1:0] m_data;
    logic [P_KEEP_WIDTH-1:0] m_keep;
    logic [P_DEST_WIDTH-1:0] m_dest;

    assign used       = wr_ptr - rd_ptr;
    assign desc_used  = desc_wr - desc_rd;
    assign desc_full  = (desc_used == DPW'(P_DESC_DEPTH));
    assign desc_empty = (desc_wr == desc_rd);

    // In DISCARD beats are swallowed without storage, so space limits do not apply.
    assign s_ready = !M_AXI_ARESET &&
                     (discard || ((used < PW'(P_FIFO_DEPTH)) && !desc_full));
    assign s_axis.tready = s_ready;
    assign s_fire        = s_axis.tvalid && s_ready;

    // tdest comes from the first beat; later beats use the latched copy.
    assign cnt_next  = beat_cnt + CW'(1);
    assign pkt_dest  = (beat_cnt == '0) ? s_axis.tdest : dest_q;
    assign commit_ok = !s_axis.tuser && (cnt_next <= CW'(P_MAX_PKT_BEATS));
    assign push      = s_fire && !discard && s_axis.tlast && commit_ok;
    assign pop       = (state == S_IDLE) && !desc_empty && i_dst_ready;

    assign {desc_dest, desc_len} = desc_mem[desc_rd[DAW-1:0]];

    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = m_data;
    assign m_axis.tlast  = m_last;
    assign m_axis.tkeep  = m_keep;
    assign m_axis.tuser  = 1'b0;
    assign m_axis.tdest  = m_dest;

    // Data RAM write port: every stored beat lands at wr_ptr.
    always_ff @(posedge M_AXI_ACLK) begin
        if (s_fire && !discard) begin
            ram[wr_ptr[AW-1:0]] <= {s_axis.tkeep, s_axis.tdata};
        end
    end

    // Descriptor RAM write port.
    always_ff @(posedge M_AXI_ACLK) begin
        if (push) begin
            desc_mem[desc_wr[DAW-1:0]] <= {pkt_dest, cnt_next};
        end
    end

    // Write side: beat counting, commit, error/oversize rewind and discard.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            beat_cnt   <= '0;
            dest_q     <= '0;
            discard    <= 1'b0;
            desc_wr    <= '0;
            o_drop_cnt <= '0;
        end else if (s_fire) begin
            if (discard) begin
                if (s_axis.tlast) begin
                    discard <= 1'b0;
                end
            end else if (s_axis.tlast) begin
                beat_cnt <= '0;
                if (commit_ok) begin
                    wr_ptr     <= wr_ptr + PW'(1);
                    commit_ptr <= wr_ptr + PW'(1);
                    desc_wr    <= desc_wr + DPW'(1);
                end else begin
                    wr_ptr     <= commit_ptr;
                    o_drop_cnt <= o_drop_cnt + 16'd1;
                end
            end else if (cnt_next == CW'(P_MAX_PKT_BEATS + 1)) begin
                // Oversize: forget what was stored and swallow the rest.
                discard    <= 1'b1;
                beat_cnt   <= '0;
                wr_ptr     <= commit_ptr;
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end else begin
                wr_ptr   <= wr_ptr + PW'(1);
                beat_cnt <= cnt_next;
                if (beat_cnt == '0) begin
                    dest_q <= s_axis.tdest;
                end
            end
        end
    end

    // Read FSM: pop a descriptor, then stream the packet out with no bubbles.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            desc_rd   <= '0;
            rem       <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_data    <= '0;
            m_keep    <= '0;
            m_dest    <= '0;
            o_pkt_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    if (pop) begin
                        desc_rd <= desc_rd + DPW'(1);
                        rem     <= desc_len;
                        m_dest  <= desc_dest;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    {m_keep, m_data} <= ram[rd_ptr[AW-1:0]];
                    m_valid <= 1'b1;
                    m_last  <= (rem == CW'(1));
                    rem     <= rem - CW'(1);
                    rd_ptr  <= rd_ptr + PW'(1);
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (m_last) begin
                        m_valid   <= 1'b0;
                        m_last    <= 1'b0;
                        o_pkt_cnt <= o_pkt_cnt + 16'd1;
                        state     <= S_IDLE;
                    end else begin
                        {m_keep, m_data} <= ram[rd_ptr[AW-1:0]];
                        m_valid <= 1'b1;
                        m_last  <= (rem == CW'(1));
                        rem     <= rem - CW'(1);
                        rd_ptr  <= rd_ptr + PW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_store_fwd.sv
// Scoreboard bench for axis_pkt_store_fwd: the driver pushes expected beats
// as they are accepted, an independent monitor pops and compares output beats.
module tb_axis_pkt_store_fwd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dst_ready = 1'b0;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    axis_pkt_store_fwd_if s_if ();
    axis_pkt_store_fwd_if m_if ();

    assign m_if.tready = 1'b1;

    axis_pkt_store_fwd dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .i_dst_ready  (dst_ready),
        .o_pkt_cnt    (pkt_cnt),
        .o_drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef logic [75:0] beat_t;   // {tdest, tlast, tkeep, tdata}

    beat_t exp_q[$];
    beat_t exp_b;
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    pkt_id = 0;
    int    last_acc_cyc = 0;
    int    start_cyc = 0;
    int    exp_pkt = 0;
    int    exp_drop = 0;
    int    st;
    bit    ignore_out = 1'b0;
    bit    prev_valid = 1'b0;
    bit    prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s bound expired", name);
    endtask

    // Monitor: compare every output beat and police gaps inside/between packets.
    always @(negedge clk) begin
        if (rst || ignore_out) begin
            prev_valid = 1'b0;
            prev_last  = 1'b0;
        end else begin
            if (prev_valid && !prev_last) check("gapless", m_if.tvalid, 1);
            if (prev_valid && prev_last)  check("pkt_gap", m_if.tvalid, 0);
            if (m_if.tvalid) begin
                if (!prev_valid) start_cyc = cyc;
                check("tuser", m_if.tuser, 0);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat", {m_if.tdest, m_if.tlast, m_if.tkeep, m_if.tdata}, exp_b);
                end
            end
            prev_valid = m_if.tvalid;
            prev_last  = m_if.tlast;
        end
    end

    // Drive one packet; called and returns at a negedge. tdest is corrupted
    // after beat 1 to make sure the DUT latches it from the first beat.
    task automatic send_pkt(input int len, input logic [2:0] dest, input logic err,
                            input logic [7:0] last_keep, input bit partial,
                            input bit expect_out, output int stalls);
        logic [63:0] d;
        logic        lst;
        logic [7:0]  kp;
        int          w;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            d   = {16'(pkt_id), 16'hC0DE, 32'(i)};
            lst = (i == len - 1) && !partial;
            kp  = lst ? last_keep : 8'hFF;
            s_if.tvalid = 1'b1;
            s_if.tdata  = d;
            s_if.tlast  = lst;
            s_if.tkeep  = kp;
            s_if.tuser  = lst ? err : 1'b0;
            s_if.tdest  = (i == 0) ? dest : ~dest;
            w = 0;
            while (!s_if.tready && w < 2000) begin
                @(negedge clk);
                w++;
                stalls++;
            end
            if (w >= 2000) begin
                fail_now("tready_wait");
                s_if.tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            if (expect_out) exp_q.push_back({dest, lst, kp, d});
            @(negedge clk);
            last_acc_cyc = cyc;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        pkt_id++;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) fail_now("drain");
        repeat (4) @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
        check({tag, "_drop_cnt"}, drop_cnt, exp_drop);
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = '0;
        s_if.tuser  = 1'b0;
        s_if.tdest  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tready", s_if.tready, 0);
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tlast", m_if.tlast, 0);
        check("rst_tdest", m_if.tdest, 0);
        check_counts("rst");
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_reset", s_if.tready, 1);

        // 4-beat packet, tdest 5, short last beat, 2-cycle release latency
        dst_ready = 1'b1;
        send_pkt(4, 3'd5, 1'b0, 8'h0F, 1'b0, 1'b1, st);
        wait_drain();
        check("latency", start_cyc - last_acc_cyc, 2);
        exp_pkt = 1;
        check_counts("t1");

        // Errored packet is dropped, the good one behind it is forwarded
        send_pkt(3, 3'd2, 1'b1, 8'h03, 1'b0, 1'b0, st);
        send_pkt(2, 3'd6, 1'b0, 8'h01, 1'b0, 1'b1, st);
        wait_drain();
        exp_pkt = 2;
        exp_drop = 1;
        check_counts("t2");

        // Oversize packet is swallowed without stalling; single-beat follows
        send_pkt(300, 3'd1, 1'b0, 8'hFF, 1'b0, 1'b0, st);
        check("oversize_stalls", st, 0);
        send_pkt(1, 3'd7, 1'b0, 8'h07, 1'b0, 1'b1, st);
        wait_drain();
        exp_pkt = 3;
        exp_drop = 2;
        check_counts("t3");

        // Fill the RAM with eight 64-beat packets while downstream is blocked
        dst_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send_pkt(64, 3'(k), 1'b0, 8'hFF, 1'b0, 1'b1, st);
            check("fill_stalls", st, 0);
            if (k == 6) check("tready_at_448", s_if.tready, 1);
        end
        check("tready_at_512", s_if.tready, 0);
        repeat (5) @(negedge clk);
        check("held_no_output", m_if.tvalid, 0);
        dst_ready = 1'b1;
        wait_drain();
        exp_pkt = 11;
        check_counts("t4");

        // Traffic across the RAM wrap with commits overlapping pops
        send_pkt(250, 3'd3, 1'b0, 8'h3F, 1'b0, 1'b1, st);
        send_pkt(240, 3'd4, 1'b0, 8'h7F, 1'b0, 1'b1, st);
        for (int k = 0; k < 30; k++) begin
            send_pkt(3, 3'(k % 8), 1'b0, 8'hFF >> (k % 8), 1'b0, 1'b1, st);
            if (k == 15) send_pkt(5, 3'd2, 1'b1, 8'hFF, 1'b0, 1'b0, st);
        end
        send_pkt(97, 3'd0, 1'b0, 8'h01, 1'b0, 1'b1, st);
        wait_drain();
        exp_pkt = 11 + 33;
        exp_drop = 3;
        check_counts("t5");

        // Reset with a packet leaving and a partial packet arriving
        ignore_out = 1'b1;
        send_pkt(20, 3'd6, 1'b0, 8'hFF, 1'b0, 1'b0, st);
        repeat (3) @(negedge clk);
        send_pkt(3, 3'd1, 1'b0, 8'hFF, 1'b1, 1'b0, st);
        check("mid_output_active", m_if.tvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tvalid", m_if.tvalid, 0);
        check("mid_rst_tlast", m_if.tlast, 0);
        check("mid_rst_tdata", m_if.tdata, 0);
        check("mid_rst_tkeep", m_if.tkeep, 0);
        check("mid_rst_tdest", m_if.tdest, 0);
        check("mid_rst_tuser", m_if.tuser, 0);
        check("mid_rst_tready", s_if.tready, 0);
        exp_pkt = 0;
        exp_drop = 0;
        exp_q.delete();
        check_counts("mid_rst");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_beats_after_reset", m_if.tvalid, 0);
        end
        ignore_out = 1'b0;
        send_pkt(5, 3'd4, 1'b0, 8'h1F, 1'b0, 1'b1, st);
        wait_drain();
        exp_pkt = 1;
        check_counts("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_pkt_store_fwd.md
Name: axis_pkt_store_fwd

Overview:
Store-and-forward packet buffer sitting directly upstream of the AXI4 bus master that writes packets to DDR.
Accepts AXI-Stream packets with a destination tag and keeps each one until it is fully received and error-free.
Releases a committed packet only when the bus master signals it can take one, then streams it back-to-back with no stalls, because the bus master's stream input has no tready.

Parameters:
P_DATA_WIDTH, 64, stream data width in bits
P_KEEP_WIDTH, 8, P_DATA_WIDTH/8
P_DEST_WIDTH, 3, tdest width
P_FIFO_DEPTH, 512, data RAM depth in beats; power of 2
P_DESC_DEPTH, 16, descriptor FIFO depth in packets; power of 2
P_MAX_PKT_BEATS, 256, largest legal packet in beats; must be <= P_FIFO_DEPTH

Ports:
M_AXI_ACLK  in  1  single clock for the whole block
M_AXI_ARESET  in  1  synchronous, active-high reset
s_axis_tvalid  in  1  input beat valid
s_axis_tdata  in  P_DATA_WIDTH  input data
s_axis_tlast  in  1  last beat of packet
s_axis_tkeep  in  P_KEEP_WIDTH  byte enables; all-ones except on the last beat
s_axis_tuser  in  1  error flag, sampled on the tlast beat
s_axis_tdest  in  P_DEST_WIDTH  destination tag, sampled on the first beat
s_axis_tready  out  1  input ready
i_dst_ready  in  1  level signal: downstream can accept one whole packet
m_axis_tvalid  out  1  output beat valid; downstream cannot stall it
m_axis_tdata  out  P_DATA_WIDTH  output data
m_axis_tlast  out  1  last beat of packet
m_axis_tkeep  out  P_KEEP_WIDTH  byte enables
m_axis_tuser  out  1  always 0 (error packets never leave the block)
m_axis_tdest  out  P_DEST_WIDTH  destination tag, constant for the whole packet
o_pkt_cnt  out  16  packets forwarded; wraps
o_drop_cnt  out  16  packets dropped; wraps

Behaviour:
- Clock and reset: M_AXI_ACLK is the only clock. M_AXI_ARESET is synchronous and active-high.
- Reset values: all outputs 0, including s_axis_tready. Pointers, counters, descriptor FIFO and FSM are cleared. s_axis_tready may rise the first cycle after reset deasserts.
- Reset mid-packet: the partial input packet and any in-flight output packet are abandoned; no further output beats.
- Storage: data RAM entries are {tkeep, tdata}. Pointers wr_ptr, commit_ptr and rd_ptr are log2(P_FIFO_DEPTH)+1 bits wide, using the extra-bit wrap scheme.
- Used space: used = wr_ptr - rd_ptr, modulo 2^(log2(P_FIFO_DEPTH)+1).
- s_axis_tready = 1 when all of the following hold:
  - used < P_FIFO_DEPTH
  - the descriptor FIFO is not full
  - the block is not in reset
  - Exception: in DISCARD, s_axis_tready = 1 unconditionally.
- Accepting a beat: a beat is taken when s_axis_tvalid and s_axis_tready are both 1. It is written at wr_ptr and wr_ptr increments. The per-packet beat counter increments; tdest is latched on beat 1.
- Commit on tlast, when tuser = 0 and beat count <= P_MAX_PKT_BEATS:
  - commit_ptr takes wr_ptr+1.
  - Descriptor {tdest, beat count (9 bits)} is pushed.
- Drop on tlast with tuser = 1: wr_ptr rewinds to commit_ptr, o_drop_cnt increments, no descriptor is pushed.
- Oversize: when beat P_MAX_PKT_BEATS+1 is accepted without tlast, the write side enters DISCARD.
  - wr_ptr rewinds to commit_ptr and o_drop_cnt increments once.
  - Remaining beats are accepted and discarded through tlast, then the write side returns to normal.
- A packet that is never committed is never visible to the read side.
- Read FSM states: IDLE, LOAD, SEND.
  - IDLE -> LOAD when the descriptor FIFO is not empty and i_dst_ready = 1. The descriptor is popped and the first RAM read is issued (1-cycle RAM latency).
  - LOAD -> SEND: m_axis_tvalid rises.
  - SEND: one beat per cycle, with no bubbles, for exactly the descriptor's beat count. rd_ptr increments per beat. m_axis_tlast is set on the final beat. m_axis_tdest is held from the descriptor.
  - SEND -> IDLE after the last beat; o_pkt_cnt increments. i_dst_ready is re-sampled only in IDLE.
- Timing: latency from IDLE pop to the first m_axis_tvalid is 2 cycles. There is a minimum 1-cycle gap between packets.
- Single-beat packet: tvalid and tlast are both high for one cycle.
- Simultaneous events: commit and pop in the same cycle both take effect. Descriptor push and pop in the same cycle keep the count unchanged. A write beat and a read beat in the same cycle keep used unchanged.
- Wrap-around: packets may straddle the RAM end; addresses wrap modulo P_FIFO_DEPTH.
- Ordering: packets leave in commit order.

Test Plan:
- 4-beat packet, tdest=5, last tkeep=0x0F, i_dst_ready=1 -> 2 cycles after pop: 4 consecutive valid beats with matching data, tdest=5, tlast on beat 4, tkeep 0xFF,0xFF,0xFF,0x0F; o_pkt_cnt=1.
- 3-beat packet with tuser=1 on tlast, then a 2-beat good packet -> only the 2-beat packet is output; o_drop_cnt=1, o_pkt_cnt=1.
- 300-beat packet -> dropped, s_axis_tready stays 1 throughout, o_drop_cnt=1; a following 1-beat packet is forwarded as a single tvalid+tlast beat.
- i_dst_ready=0, push 64-beat packets until s_axis_tready=0 -> tready falls at used=512; set i_dst_ready=1 -> eight packets out in order, each gapless, with >=1 idle cycle between packets.
- Packets straddling the RAM wrap, with simultaneous commit and pop -> data intact, no lost or duplicated descriptor.
- Assert M_AXI_ARESET mid-input and mid-output -> all outputs 0 next cycle; a fresh packet after reset is forwarded correctly.
